pattern_bank: RTL
=================

PATTERN_BANK -- requirements
Module: pattern_bank

Interface
REQ-001 SHALL have parameter NUM_BUFS, default 8: number of pattern buffers (2..16).
REQ-002 SHALL have parameter BUF_BYTES, default 32: bytes per buffer (2..64).
REQ-003 SHALL have parameter WIDTH, default 8: bits per byte (1..16).
REQ-004 SHALL define localparams AW = clog2(NUM_BUFS), FW = clog2(BUF_BYTES) and FRAME_BITS = BUF_BYTES*WIDTH.
REQ-005 SHALL have ports:
- sclk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ssel  in  1  scan frame enable.
- saddr  in  AW  scan target buffer.
- sin  in  1  scan data in.
- sout  out  1  scan data out.
- bufp  in  AW  read buffer select.
- fieldp  in  FW  read byte select.
- field_byte  out  WIDTH  registered read data.
- commit  out  1  one-cycle pulse, frame committed.
- frame_err  out  1  one-cycle pulse, frame rejected.
- busy  out  1  scan FSM not IDLE.

Function
REQ-006 SHALL hold NUM_BUFS active buffers of BUF_BYTES x WIDTH plus one shared shadow shift register of FRAME_BITS.
REQ-007 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE, COMMIT; busy = (state != IDLE).
REQ-008 IDLE with ssel=1: latch saddr into tgt and go to LOAD; IDLE with ssel=0: stay.
REQ-009 LOAD (one cycle, sin ignored): shadow <= active[tgt], bit counter <= 0; then SHIFT if ssel=1, else IDLE with frame_err.
REQ-010 SHIFT, ssel=1: shift sin into shadow bit 0 (byte 0 bit 0), moving everything toward byte BUF_BYTES-1 bit WIDTH-1, and increment the counter; go to DONE when the counter reaches the frame length.
REQ-011 sout SHALL equal shadow byte BUF_BYTES-1 bit WIDTH-1 while busy, else 0, so the scan-out stream returns the previous contents of the target buffer.
REQ-012 SHIFT with ssel=0 (short frame): pulse frame_err, leave active unchanged, go to IDLE.
REQ-013 DONE with ssel=0: go to COMMIT; DONE with ssel=1 (overrun bit): pulse frame_err, discard the frame, stay in DONE until ssel=0, then go to IDLE without committing.
REQ-014 COMMIT (one cycle): active[tgt] <= shadow, commit=1, then go to IDLE; a new frame needs ssel=0 in IDLE for at least one cycle.
REQ-015 tgt >= NUM_BUFS SHALL run the full frame and then pulse frame_err in place of COMMIT, leaving all buffers unchanged.
REQ-016 field_byte SHALL register active[bufp][fieldp] with 1-cycle latency; it SHALL be 0 if bufp >= NUM_BUFS or fieldp >= BUF_BYTES.
REQ-017 A read of a buffer in the same cycle as its COMMIT SHALL return pre-commit data; the new data SHALL be visible the next cycle.
REQ-018 commit and frame_err SHALL never be high in the same cycle.
REQ-019 saddr changes while busy SHALL be ignored.

Reset
REQ-020 rst_n low SHALL asynchronously force state=IDLE, counter=0, tgt=0, shadow=0, all active buffers=0, field_byte=0, sout=0, commit=0, frame_err=0 and busy=0.
REQ-021 Reset asserted mid-frame SHALL abort the frame, and no commit SHALL follow reset release.

Configuration
REQ-022 With PATTERN_BANK_PARITY_EN defined, the frame length SHALL be FRAME_BITS+1; the final bit is an even-parity bit that is not stored, and COMMIT occurs only if the XOR of all FRAME_BITS+1 bits is 0, else frame_err in place of COMMIT.
REQ-023 Without PATTERN_BANK_PARITY_EN, the frame length SHALL be FRAME_BITS and no parity logic SHALL exist.

Verification (defaults 8/32/8, macro undefined unless stated)
REQ-024 Reset, then scan 256 bits of 0xA5 per byte into saddr=3 -> commit pulse 1 cycle after ssel falls; bufp=3, fieldp=17 -> field_byte=0xA5 one cycle later; other buffers read 0x00.
REQ-025 Rescan buffer 3 with 0x3C pattern -> sout emits 256 bits reproducing the 0xA5 contents; afterwards buffer 3 reads 0x3C.
REQ-026 Drop ssel after 100 shifted bits -> frame_err pulse, no commit, buffer 3 still 0x3C; drop ssel after 257 bits -> frame_err, no commit.
REQ-027 Hold bufp=3, fieldp=0 through COMMIT of 0xFF -> field_byte=0x3C in the commit cycle's result, 0xFF the cycle after.
REQ-028 Assert rst_n=0 at bit 128 of a frame -> busy=0 and outputs 0 immediately; no commit after release; all reads return 0x00.
REQ-029 PATTERN_BANK_PARITY_EN defined: 257-bit frame with correct parity -> commit; same frame with parity bit flipped -> frame_err, buffer unchanged.

Source files
------------

// File: rtl/pattern_bank.sv
// Scan-loaded pattern bank: a serial frame is staged in a shadow shift register and committed
// atomically to one of NUM_BUFS buffers. Define PATTERN_BANK_PARITY_EN to append an even-parity bit.
module pattern_bank #(
  parameter  int NUM_BUFS   = 8,
  parameter  int BUF_BYTES  = 32,
  parameter  int WIDTH      = 8,
  localparam int AW         = $clog2(NUM_BUFS),
  localparam int FW         = $clog2(BUF_BYTES),
  localparam int FRAME_BITS = BUF_BYTES * WIDTH
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             ssel,
  input  logic [AW-1:0]    saddr,
  input  logic             sin,
  output logic             sout,
  input  logic [AW-1:0]    bufp,
  input  logic [FW-1:0]    fieldp,
  output logic [WIDTH-1:0] field_byte,
  output logic             commit,
  output logic             frame_err,
  output logic             busy
);

`ifdef PATTERN_BANK_PARITY_EN
  localparam int FRAME_LEN = FRAME_BITS + 1;
`else
  localparam int FRAME_LEN = FRAME_BITS;
`endif
  localparam int            CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, COMMIT} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [AW-1:0]           tgt;
  logic [FRAME_BITS-1:0]   shadow;
  logic [FRAME_BITS-1:0]   load_data;
  logic                    ovr;
  logic                    tgt_ok;
  logic                    buf_ok;
  logic                    fld_ok;
  logic                    frame_ok;
  logic [WIDTH-1:0]        mem [NUM_BUFS][BUF_BYTES];

  // Range checks collapse to constants when the index space is exactly filled.
  if (NUM_BUFS == (1 << AW)) begin : g_buf_full
    assign tgt_ok = 1'b1;
    assign buf_ok = 1'b1;
  end else begin : g_buf_part
    assign tgt_ok = (tgt  < AW'(NUM_BUFS));
    assign buf_ok = (bufp < AW'(NUM_BUFS));
  end

  if (BUF_BYTES == (1 << FW)) begin : g_fld_full
    assign fld_ok = 1'b1;
  end else begin : g_fld_part
    assign fld_ok = (fieldp < FW'(BUF_BYTES));
  end

`ifdef PATTERN_BANK_PARITY_EN
  logic par;
  assign frame_ok = tgt_ok & ~par;
`else
  assign frame_ok = tgt_ok;
`endif

  assign busy = (state != IDLE);
  assign sout = busy & shadow[FRAME_BITS-1];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    load_data = '0;
    if (tgt_ok)
      for (int i = 0; i < BUF_BYTES; i++)
        load_data[i*WIDTH +: WIDTH] = mem[tgt][i];
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tgt       <= '0;
      shadow    <= '0;
      ovr       <= 1'b0;
      commit    <= 1'b0;
      frame_err <= 1'b0;
`ifdef PATTERN_BANK_PARITY_EN
      par       <= 1'b0;
`endif
      // NOTE: buffers are flops rather than a RAM because reset must clear every byte asynchronously.
      for (int b = 0; b < NUM_BUFS; b++)
        for (int i = 0; i < BUF_BYTES; i++)
          mem[b][i] <= '0;
    end else begin
      commit    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ssel) begin
            tgt   <= saddr;
            state <= LOAD;
          end
        end
        LOAD: begin
          shadow <= load_data;
          cnt    <= '0;
          ovr    <= 1'b0;
`ifdef PATTERN_BANK_PARITY_EN
          par    <= 1'b0;
`endif
          if (ssel) begin
            state <= SHIFT;
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        SHIFT: begin
          if (ssel) begin
            cnt <= cnt + 1'b1;
`ifdef PATTERN_BANK_PARITY_EN
            par <= par ^ sin;
            // The trailing parity bit is checked but never stored.
            if (cnt != CNT_LAST) shadow <= {shadow[FRAME_BITS-2:0], sin};
`else
            shadow <= {shadow[FRAME_BITS-2:0], sin};
`endif
            if (cnt == CNT_LAST) state <= DONE;
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        DONE: begin
          if (ssel) begin
            if (!ovr) frame_err <= 1'b1;
            ovr <= 1'b1;
          end else if (ovr) begin
            state <= IDLE;
          end else begin
            commit    <= frame_ok;
            frame_err <= ~frame_ok;
            state     <= COMMIT;
          end
        end
        COMMIT: begin
          // commit is high exactly when this frame is accepted.
          if (commit)
            for (int i = 0; i < BUF_BYTES; i++)
              mem[tgt][i] <= shadow[i*WIDTH +: WIDTH];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n)
      field_byte <= '0;
    else if (buf_ok && fld_ok)
      field_byte <= mem[bufp][fieldp];
    else
      field_byte <= '0;
  end

endmodule
